fifo_stream_reader: RTL and testbench



---
 rtl/utils_pkg.sv | 8 +
 rtl/ring_buffer.sv | 58 +++++
 rtl/fifo_stream_reader.sv | 62 ++++++
 tb/tb_fifo_stream_reader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared elaboration-time helper functions
package utils_pkg;

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/ring_buffer.sv
// rtl/ring_buffer.sv - single-clock register ring buffer with separate occupancy count
module ring_buffer #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             data_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  head_q;
    logic [PtrW-1:0]  tail_q;
    logic [CntW-1:0]  count_q;
    logic             do_pop;

    // Popping an empty buffer is a no-op so callers need not gate pop_i.
    assign do_pop  = pop_i && (count_q != '0);
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (do_pop) begin
                head_q <= head_q + 1'b1;
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_i && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - turns the CDC FIFO read port into a prefetched valid/ready stream
module fifo_stream_reader
    import utils_pkg::*;
#(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         fifo_valid_i,
    output logic                         fifo_req_o,
    input  logic [Width-1:0]             fifo_data_i,
    input  logic                         flush_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [Width-1:0]             data_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int CntW = $clog2(Depth + 1);

    if (!is_pow2(Depth) || Depth < 2) begin : g_depth_check
        $error("fifo_stream_reader: Depth must be a power of 2 and at least 2");
    end

    logic            inflight_q;
    logic [CntW:0]   reserved;
    logic            push;
    logic            pop;

    // Every in-flight word already owns a slot, so the buffer can never overflow.
    assign reserved   = {1'b0, count_o} + {{CntW{1'b0}}, inflight_q};
    assign fifo_req_o = fifo_valid_i && !rst_i && !flush_i
                        && (reserved < (CntW + 1)'(Depth));

    assign valid_o = (count_o != '0);
    assign push    = inflight_q && !flush_i;
    assign pop     = valid_o && ready_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_req_o && fifo_valid_i;
        end
    end

    ring_buffer #(
        .Width (Width),
        .Depth (Depth)
    ) u_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (push),
        .data_i  (fifo_data_i),
        .pop_i   (pop),
        .data_o  (data_o),
        .count_o (count_o)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed bench for fifo_stream_reader at Depth 4 and Depth 2
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       fv   [2];
    logic       rdy  [2];
    logic       fl   [2];
    logic [7:0] fd   [2];
    logic       req  [2];
    logic       vld  [2];
    logic [7:0] dout [2];
    logic [2:0] cnt0;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    fifo_stream_reader #(.Width(8), .Depth(4)) dut (
        .clk_i(clk), .rst_i(rst), .fifo_valid_i(fv[0]), .fifo_req_o(req[0]),
        .fifo_data_i(fd[0]), .flush_i(fl[0]), .valid_o(vld[0]), .ready_i(rdy[0]),
        .data_o(dout[0]), .count_o(cnt0)
    );

    fifo_stream_reader #(.Width(8), .Depth(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .fifo_valid_i(fv[1]), .fifo_req_o(req[1]),
        .fifo_data_i(fd[1]), .flush_i(fl[1]), .valid_o(vld[1]), .ready_i(rdy[1]),
        .data_o(dout[1]), .count_o(cnt1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Source FIFO and scoreboard: words are consecutive integers per instance.
    int depth_of [2] = '{4, 2};
    int src_next [2];
    int src_end  [2];
    int exp_next [2];
    int pend_word[2];
    bit pend     [2];
    bit gate     [2];
    int rmode    [2];
    int first_grant[2];
    int cons_n     [2];
    int cons_first [2];
    int cons_last  [2];
    int cyc = 0;

    typedef struct {
        logic       fv;
        logic       rdy;
        logic       fl;
        logic [7:0] fd;
        logic       req;
        logic       vld;
        int         cnt;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_of(input int k);
        return (k == 0) ? int'(cnt0) : int'(cnt1);
    endfunction

    task automatic load(input int k, input int first, input int n);
        src_next[k] = first;
        exp_next[k] = first;
        src_end[k]  = first + n;
    endtask

    task automatic tick();
        int  ref_n;
        int  expc;
        bit  ereq;
        bit  g [2];
        for (int k = 0; k < 2; k++) begin
            fv[k] = gate[k] && (src_next[k] < src_end[k]);
            fd[k] = pend[k] ? 8'(pend_word[k]) : 8'hEE;
            case (rmode[k])
                0:       rdy[k] = 1'b0;
                1:       rdy[k] = 1'b1;
                default: rdy[k] = 1'($urandom_range(0, 1));
            endcase
        end
        #3;
        for (int k = 0; k < 2; k++) begin
            ref_n = src_next[k] - exp_next[k];
            expc  = ref_n - int'(pend[k]);
            chk($sformatf("count[%0d] cyc %0d", k, cyc), cnt_of(k), expc);
            chk($sformatf("valid[%0d] cyc %0d", k, cyc), int'(vld[k]), int'(expc != 0));
            if (k == 1) chk($sformatf("count_max[1] cyc %0d", cyc), int'(cnt1 <= 2'd2), 1);
            ereq = fv[k] && !rst && !fl[k] && (ref_n < depth_of[k]);
            chk($sformatf("req[%0d] cyc %0d", k, cyc), int'(req[k]), int'(ereq));
            if (vld[k] && rdy[k] && !fl[k] && !rst) begin
                chk($sformatf("data[%0d] cyc %0d", k, cyc), int'(dout[k]), exp_next[k] & 255);
                exp_next[k]++;
                if (cons_n[k] == 0) cons_first[k] = cyc;
                cons_last[k] = cyc;
                cons_n[k]++;
            end
            g[k] = ereq;
            if (ereq && first_grant[k] < 0) first_grant[k] = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst || fl[k]) begin
                pend[k]     = 1'b0;
                exp_next[k] = src_next[k];
            end else begin
                pend[k] = g[k];
                if (g[k]) begin
                    pend_word[k] = src_next[k];
                    src_next[k]++;
                end
            end
        end
    endtask

    initial begin
        // fv rdy fl fd | req vld cnt dout   (Depth 4 instance)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1, 1, 8'h11};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 2, 8'h11};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 3, 8'h11};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 4, 8'h11};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 4, 8'h11};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 3, 8'h22};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 3, 8'h22};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'hB6, 1'b0, 1'b0, 0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b1, 1, 8'hB6};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 0, 8'h00};

        for (int k = 0; k < 2; k++) begin
            fv[k] = 1'b1; rdy[k] = 1'b1; fl[k] = 1'b0; fd[k] = 8'hEE;
            pend[k] = 1'b0; gate[k] = 1'b0; rmode[k] = 0;
            src_next[k] = 0; src_end[k] = 0; exp_next[k] = 0; pend_word[k] = 0;
            first_grant[k] = -1; cons_n[k] = 0; cons_first[k] = 0; cons_last[k] = 0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset valid[0]", int'(vld[0]), 0);
        chk("reset count[0]", int'(cnt0), 0);
        chk("reset req[0]", int'(req[0]), 0);
        chk("reset req[1]", int'(req[1]), 0);
        chk("reset data[0]", int'(dout[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fv[1] = 1'b0;
        rdy[1] = 1'b0;

        for (int i = 0; i < 13; i++) begin
            fv[0] = tbl[i].fv; rdy[0] = tbl[i].rdy; fl[0] = tbl[i].fl; fd[0] = tbl[i].fd;
            #3;
            chk($sformatf("tbl%0d req", i), int'(req[0]), int'(tbl[i].req));
            chk($sformatf("tbl%0d valid", i), int'(vld[0]), int'(tbl[i].vld));
            chk($sformatf("tbl%0d count", i), int'(cnt0), tbl[i].cnt);
            if (tbl[i].vld) chk($sformatf("tbl%0d data", i), int'(dout[0]), int'(tbl[i].dout));
            @(posedge clk);
            #1;
        end
        fl[0] = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Streaming 0x01..0x10 at full rate.
        load(0, 'h01, 16);
        gate[0] = 1'b1; rmode[0] = 1;
        first_grant[0] = -1; cons_n[0] = 0;
        for (int i = 0; i < 24; i++) tick();
        chk("stream consumed", cons_n[0], 16);
        chk("stream latency", cons_first[0] - first_grant[0], 2);
        chk("stream back-to-back", cons_last[0] - cons_first[0], 15);

        // Backpressure: 10 words, consumer stalled.
        load(0, 'h20, 10);
        rmode[0] = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("bp count settles", int'(cnt0), 4);
        chk("bp req stops", int'(req[0]), 0);
        rmode[0] = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("bp drained", exp_next[0], src_end[0]);

        // Reset with 3 buffered and 1 in flight.
        load(0, 'h40, 16);
        rmode[0] = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre-reset count", int'(cnt0), 3);
        chk("pre-reset inflight", int'(pend[0]), 1);
        rst = 1'b1;
        tick();
        chk("post-reset valid", int'(vld[0]), 0);
        chk("post-reset count", int'(cnt0), 0);
        chk("req held low in reset", int'(req[0]), 0);
        rst = 1'b0;
        rmode[0] = 1;
        for (int i = 0; i < 24; i++) tick();
        chk("post-reset drained", exp_next[0], src_end[0]);

        // Sparse source on Depth 4, wrap-around on Depth 2, random ready.
        load(0, 'h60, 20);
        load(1, 'h80, 37);
        rmode[0] = 2; rmode[1] = 2; gate[1] = 1'b1;
        for (int i = 0; i < 300; i++) begin
            gate[0] = (i % 2 == 0);
            tick();
        end
        chk("sparse drained", exp_next[0], src_end[0]);
        chk("wrap drained", exp_next[1], src_end[1]);
        chk("wrap count empty", int'(cnt1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
